// File: rtl/bnn_acc_cfu_pkg.sv
// bnn_acc_cfu_pkg: function codes, pipeline stage record and popcount helper for bnn_acc_cfu
package bnn_acc_cfu_pkg;
  localparam int BNN_MAX_W = 64;
  localparam int BNN_POP_W = 7;
  localparam int BNN_STATE_W = 8;
  typedef enum logic [2:0] {
    BNN_DOT = 3'd0,
    BNN_MAC = 3'd1,
    BNN_READ = 3'd2,
    BNN_CLEAR = 3'd3,
    BNN_THRESH = 3'd4,
    BNN_BAD = 3'd7
  } bnn_func_e;
  typedef struct packed {
    logic valid;
    logic [2:0] func;
    logic [BNN_STATE_W-1:0] state;
    logic [BNN_MAX_W-1:0] thresh;
    logic [BNN_POP_W-1:0] pop;
  } bnn_stage_t;
  function automatic logic [BNN_POP_W-1:0] bnn_popcount(logic [BNN_MAX_W-1:0] x);
    logic [BNN_POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < BNN_MAX_W; i++) n += BNN_POP_W'(x[i]);
    return n;
  endfunction
endpackage

// File: rtl/cfu_pkg.sv
// cfu_pkg: shared CFU-L2 constants, status codes and parameter check
package cfu_pkg;
  localparam int CFU_L2_VERSION = 1;
  localparam int CFU_STATUS_W = 3;
  localparam logic [CFU_STATUS_W-1:0] CFU_OK = 3'd0;
  localparam logic [CFU_STATUS_W-1:0] CFU_ERROR = 3'd1;
  function automatic bit check_cfu_l2_params(int version, int n_cfus, int func_id_w);
    return version == CFU_L2_VERSION && n_cfus >= 1 && func_id_w >= 1;
  endfunction
endpackage

// File: rtl/bnn_acc_cfu_popcount_pipe.sv
// bnn_popcount_pipe: xnor-popcount of a and b with STAGES-1 register stages, carrying a sideband alongside
// ports: clk, rst_n (async active-low), en (shift enable), a/b operands, side_in -> pop, side_out
module bnn_popcount_pipe import bnn_acc_cfu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int STAGES = 1,
  parameter int SIDE_W = 1,
  localparam int PW = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [SIDE_W-1:0] side_in,
  output logic [PW-1:0]     pop,
  output logic [SIDE_W-1:0] side_out
);
  localparam int H = WIDTH / 2;
  logic [WIDTH-1:0] x;
  logic [BNN_POP_W-1:0] lo, hi;
  assign x = a ~^ b;
  assign lo = bnn_popcount(BNN_MAX_W'(x[H-1:0]));
  assign hi = bnn_popcount(BNN_MAX_W'(x[WIDTH-1:H]));
  if (STAGES == 2) begin : g_reg
    logic [BNN_POP_W-1:0] lo_q, hi_q;
    logic [SIDE_W-1:0] side_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        lo_q <= '0;
        hi_q <= '0;
        side_q <= '0;
      end else if (en) begin
        lo_q <= lo;
        hi_q <= hi;
        side_q <= side_in;
      end
    assign pop = PW'(lo_q + hi_q);
    assign side_out = side_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n ^ en;
    assign pop = PW'(lo + hi);
    assign side_out = side_in;
  end
endmodule

// File: rtl/bnn_acc_cfu.sv
// bnn_acc_cfu: pipelined XNOR-popcount CFU with per-state accumulators and valid/ready backpressure
// ports: clk, rst_n (async active-low); req_valid/req_ready, req_cfu (unused), req_state, req_func,
//        req_data0 (operand a / threshold), req_data1 (operand b); resp_valid/resp_ready, resp_status, resp_data
module bnn_acc_cfu import cfu_pkg::*; import bnn_acc_cfu_pkg::*; #(
  parameter int CFU_VERSION = CFU_L2_VERSION,
  parameter int CFU_N_CFUS = 1,
  parameter int CFU_CFU_ID_W = 0,
  parameter int CFU_FUNC_ID_W = 3,
  parameter int CFU_DATA_W = 32,
  parameter int CFU_N_STATES = 4,
  parameter int POP_STAGES = 1,
  parameter int ACC_W = CFU_DATA_W,
  localparam int CFU_STATE_ID_W = CFU_N_STATES > 2 ? $clog2(CFU_N_STATES) : 1,
  localparam int CFU_ID_PORT_W = CFU_CFU_ID_W > 0 ? CFU_CFU_ID_W : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CFU_ID_PORT_W-1:0]  req_cfu,
  input  logic [CFU_STATE_ID_W-1:0] req_state,
  input  logic [CFU_FUNC_ID_W-1:0]  req_func,
  input  logic [CFU_DATA_W-1:0]     req_data0,
  input  logic [CFU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [CFU_STATUS_W-1:0]   resp_status,
  output logic [CFU_DATA_W-1:0]     resp_data
);
  localparam int PW = $clog2(CFU_DATA_W + 1);
  if (!check_cfu_l2_params(CFU_VERSION, CFU_N_CFUS, CFU_FUNC_ID_W) ||
      !(CFU_DATA_W == 32 || CFU_DATA_W == 64) || !(POP_STAGES == 1 || POP_STAGES == 2) ||
      ACC_W < 1 || ACC_W > CFU_DATA_W || CFU_N_STATES < 1 || CFU_N_STATES > 256) begin : g_bad_params
    $error("bnn_acc_cfu: illegal parameter combination");
  end
  logic advance;
  logic [31:0] func32;
  bnn_stage_t st_in, s;
  logic [$bits(bnn_stage_t)-1:0] side;
  logic [PW-1:0] pop;
  logic [ACC_W-1:0] acc [CFU_N_STATES];
  logic [ACC_W-1:0] acc_cur, acc_sum, acc_nxt;
  logic state_ok, ok, acc_we;
  logic [CFU_DATA_W-1:0] data;
  logic unused_bits;
  assign advance = !resp_valid || resp_ready;
  assign req_ready = advance;
  assign func32 = 32'(req_func);
  assign unused_bits = ^{req_cfu, s.thresh};
  // Undefined function codes collapse to BNN_BAD at entry so the stage record stays 3 bits wide.
  always_comb begin
    st_in = '0;
    st_in.valid = req_valid;
    st_in.func = func32 > 32'd4 ? BNN_BAD : func32[2:0];
    st_in.state = BNN_STATE_W'(req_state);
    st_in.thresh = BNN_MAX_W'(req_data0);
  end
  bnn_popcount_pipe #(
    .WIDTH(CFU_DATA_W),
    .STAGES(POP_STAGES),
    .SIDE_W($bits(bnn_stage_t))
  ) u_pop (
    .clk(clk),
    .rst_n(rst_n),
    .en(advance),
    .a(req_data0),
    .b(req_data1),
    .side_in(st_in),
    .pop(pop),
    .side_out(side)
  );
  // Final stage: all accumulator reads and writes happen here, so in-order commit needs no forwarding.
  always_comb begin
    s = side;
    s.pop = BNN_POP_W'(pop);
    acc_cur = '0;
    for (int i = 0; i < CFU_N_STATES; i++) if (s.state == BNN_STATE_W'(i)) acc_cur = acc[i];
    state_ok = 32'(s.state) < 32'(CFU_N_STATES);
    acc_sum = acc_cur + ACC_W'(s.pop);
    ok = s.func == BNN_DOT || (s.func <= BNN_THRESH && state_ok);
    data = !ok ? '0 :
           s.func == BNN_DOT ? CFU_DATA_W'(s.pop) :
           s.func == BNN_MAC ? CFU_DATA_W'(acc_sum) :
           s.func == BNN_THRESH ? CFU_DATA_W'(acc_cur >= s.thresh[ACC_W-1:0]) :
           CFU_DATA_W'(acc_cur);
    acc_we = advance && s.valid && ok && (s.func == BNN_MAC || s.func == BNN_CLEAR);
    acc_nxt = s.func == BNN_MAC ? acc_sum : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CFU_N_STATES; i++) acc[i] <= '0;
    end else if (acc_we) begin
      for (int i = 0; i < CFU_N_STATES; i++) if (s.state == BNN_STATE_W'(i)) acc[i] <= acc_nxt;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_status <= CFU_OK;
    end else if (advance) begin
      resp_valid <= s.valid;
      if (s.valid) begin
        resp_data <= data;
        resp_status <= ok ? CFU_OK : CFU_ERROR;
      end
    end
endmodule

// File: tb/tb_bnn_acc_cfu.sv
// tb_bnn_acc_cfu: scoreboard bench running two configurations (32b/1 stage/8b acc, 64b/2 stages/64b acc)
module tb_bnn_acc_cfu;
  import cfu_pkg::*;
  typedef struct {
    logic [2:0] st;
    logic [63:0] d;
  } exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int DW = g == 0 ? 32 : 64;
    localparam int PS = g == 0 ? 1 : 2;
    localparam int AW = g == 0 ? 8 : 64;
    localparam int NS = g == 0 ? 4 : 5;
    localparam int SW = NS > 2 ? $clog2(NS) : 1;
    localparam logic [63:0] DMASK = DW == 64 ? {64{1'b1}} : (64'd1 << DW) - 64'd1;
    localparam logic [63:0] AMASK = AW == 64 ? {64{1'b1}} : (64'd1 << AW) - 64'd1;
    logic rst_n, req_valid, req_ready, req_cfu, resp_valid, resp_ready;
    logic [SW-1:0] req_state;
    logic [2:0] req_func;
    logic [DW-1:0] req_data0, req_data1, resp_data;
    logic [CFU_STATUS_W-1:0] resp_status;
    exp_t sb[$];
    logic [63:0] model_acc [8];
    bit done = 0;
    bit rand_rdy = 0;
    bnn_acc_cfu #(
      .CFU_DATA_W(DW),
      .CFU_N_STATES(NS),
      .POP_STAGES(PS),
      .ACC_W(AW)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_cfu(req_cfu),
      .req_state(req_state),
      .req_func(req_func),
      .req_data0(req_data0),
      .req_data1(req_data1),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_status(resp_status),
      .resp_data(resp_data)
    );
    // Reference: the function table applied to an array of accumulator values in issue order.
    function automatic exp_t predict(input logic [2:0] f, input int s, input logic [63:0] a, input logic [63:0] b);
      exp_t e;
      logic [63:0] p;
      p = 64'($countones(~(a ^ b) & DMASK));
      e.st = CFU_ERROR;
      e.d = '0;
      if (f == 3'd0) begin
        e.st = CFU_OK;
        e.d = p;
      end else if (f <= 3'd4 && s < NS) begin
        e.st = CFU_OK;
        if (f == 3'd1) begin
          model_acc[s] = (model_acc[s] + p) & AMASK;
          e.d = model_acc[s];
        end else if (f == 3'd2) e.d = model_acc[s];
        else if (f == 3'd3) begin
          e.d = model_acc[s];
          model_acc[s] = '0;
        end else e.d = model_acc[s] >= (a & AMASK) ? 64'd1 : 64'd0;
      end
      return e;
    endfunction
    function automatic logic [63:0] mism(input int p);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < DW - p; i++) m[i] = 1'b1;
      return m;
    endfunction
    task automatic issue(input logic [2:0] f, input int s, input logic [63:0] a, input logic [63:0] b);
      req_valid = 1'b1;
      req_func = f;
      req_state = SW'(s);
      req_data0 = DW'(a);
      req_data1 = DW'(b);
      for (int n = 0; ; n++) begin
        @(negedge clk);
        if (req_ready) begin
          sb.push_back(predict(f, s, a & DMASK, b & DMASK));
          break;
        end
        if (n == 200) begin
          checks++;
          errors++;
          $display("FAIL cfg%0d accept_timeout: req_ready=%0b required 1", g, req_ready);
          break;
        end
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
    endtask
    task automatic drain();
      for (int n = 0; n <= 500; n++) begin
        @(negedge clk);
        if (sb.size() == 0) break;
        if (n == 500) begin
          checks++;
          errors++;
          $display("FAIL cfg%0d drain_timeout: pending=%0d required 0", g, sb.size());
        end
      end
      @(posedge clk);
      #1;
    endtask
    task automatic issue_p(input logic [2:0] f, input int s, input int p);
      logic [63:0] a;
      a = {$urandom, $urandom};
      issue(f, s, a, a ^ mism(p));
    endtask
    initial begin : rdy_drv
      forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) resp_ready = $urandom_range(0, 3) != 0;
      end
    end
    initial begin : mon
      bit held;
      logic [63:0] hd;
      logic [2:0] hs;
      exp_t e;
      held = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) held = 0;
        else begin
          if (held) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== hd[DW-1:0] || resp_status !== hs) begin
              errors++;
              $display("FAIL cfg%0d hold: valid=%0b data=%0h status=%0d required valid=1 data=%0h status=%0d",
                       g, resp_valid, resp_data, resp_status, hd[DW-1:0], hs);
            end
          end
          if (resp_valid && resp_ready) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL cfg%0d unexpected_resp: data=%0h status=%0d required no response", g, resp_data, resp_status);
            end else begin
              e = sb.pop_front();
              if (resp_data !== e.d[DW-1:0] || resp_status !== e.st) begin
                errors++;
                $display("FAIL cfg%0d resp: data=%0h status=%0d required data=%0h status=%0d",
                         g, resp_data, resp_status, e.d[DW-1:0], e.st);
              end
            end
            held = 0;
          end else begin
            held = resp_valid;
            hd = 64'(resp_data);
            hs = resp_status;
          end
        end
      end
    end
    initial begin : stim
      int lat, tot, p;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_cfu = 1'b0;
      req_state = '0;
      req_func = '0;
      req_data0 = '0;
      req_data1 = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) model_acc[i] = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || resp_data !== '0 || resp_status !== CFU_OK || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL cfg%0d reset: valid=%0b data=%0h status=%0d ready=%0b required 0 0 %0d 1",
                 g, resp_valid, resp_data, resp_status, req_ready, CFU_OK);
      end
      @(posedge clk);
      #1;
      issue(3'd0, 0, DMASK, DMASK);
      lat = 1;
      while (!resp_valid && lat < 10) begin
        @(posedge clk);
        #1 lat++;
      end
      checks++;
      if (lat != PS) begin
        errors++;
        $display("FAIL cfg%0d latency: got %0d cycles required %0d", g, lat, PS);
      end
      drain();
      issue(3'd0, 0, 64'd0, DMASK);
      issue(3'd0, 0, 64'hF0F0F0F0F0F0F0F0, 64'hFFFF0000FFFF0000);
      issue_p(3'd1, 0, 5);
      issue_p(3'd1, 0, 7);
      issue(3'd2, 0, 64'd0, 64'd0);
      issue(3'd3, 0, 64'd0, 64'd0);
      issue(3'd2, 0, 64'd0, 64'd0);
      drain();
      resp_ready = 1'b0;
      fork
        begin
          issue_p(3'd1, 2, 3);
          issue_p(3'd1, 2, 4);
        end
        begin
          for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
          repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0) begin
              errors++;
              $display("FAIL cfg%0d stall_ready: req_ready=%0b required 0", g, req_ready);
            end
          end
          @(posedge clk);
          #1 resp_ready = 1'b1;
        end
      join
      issue(3'd2, 2, 64'd0, 64'd0);
      issue(3'd6, 0, {$urandom, $urandom}, {$urandom, $urandom});
      if (NS < (1 << SW)) issue_p(3'd1, (1 << SW) - 1, 9);
      for (int i = 0; i < NS; i++) issue(3'd2, i, 64'd0, 64'd0);
      drain();
      issue(3'd3, 1, 64'd0, 64'd0);
      tot = 0;
      while (tot < 250) begin
        p = 250 - tot < DW ? 250 - tot : DW;
        issue_p(3'd1, 1, p);
        tot += p;
      end
      issue_p(3'd1, 1, 10);
      issue(3'd4, 1, model_acc[1], 64'd0);
      issue(3'd4, 1, model_acc[1] + 64'd1, 64'd0);
      drain();
      rand_rdy = 1;
      repeat (300) begin
        issue(3'($urandom_range(0, 7)), $urandom_range(0, (1 << SW) - 1), {$urandom, $urandom}, {$urandom, $urandom});
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      rand_rdy = 0;
      resp_ready = 1'b1;
      drain();
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_func = 3'd1;
      req_state = SW'(3);
      req_data0 = '1;
      req_data1 = '1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = 1'b0;
      sb.delete();
      for (int i = 0; i < 8; i++) model_acc[i] = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      resp_ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0) begin
          errors++;
          $display("FAIL cfg%0d post_reset_resp: resp_valid=%0b required 0", g, resp_valid);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) issue(3'd2, i, 64'd0, 64'd0);
      drain();
      done = 1;
    end
  end
  initial begin
    wait (g_cfg[0].done && g_cfg[1].done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
